// File: rtl/combo_pkg.sv
// Shared state encoding and keypad constants for the combination-lock receiver.
// Used by combo_lock_rx and key_rx_sync.
package combo_pkg;

    typedef enum logic [2:0] {
        LOCKED,
        CHECK,
        OPEN,
        SET,
        LOCKOUT
    } lock_state_t;

    localparam logic [3:0] KEY_SET   = 4'hA;
    localparam logic [3:0] KEY_LOCK  = 4'hD;
    localparam logic [3:0] KEY_ENTER = 4'hE;
    localparam logic [3:0] KEY_CLEAR = 4'hF;

    function automatic logic isDigit(input logic [3:0] keyCode);
        return keyCode <= 4'h9;
    endfunction

endpackage

// File: rtl/key_rx_sync.sv
// Keypad link receiver: synchronises the remote key bus and turns each
// falling edge of the active-low valid strobe into a single-cycle key event.
module key_rx_sync
    import combo_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] key_code,
    input  logic       key_validn,
    output logic       key_strobe,
    output logic [3:0] key_last
);

    logic       r_validSync1;
    logic       r_validSync2;
    logic       r_validPrev;
    logic [3:0] r_codeSync1;
    logic [3:0] r_codeSync2;
    logic       r_strobe;
    logic [3:0] r_last;
    logic       w_fall;

    // The code bus is held stable while valid is low, so sampling it through
    // the same two stages is enough to line it up with the edge.
    assign w_fall = r_validPrev & ~r_validSync2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_validSync1 <= 1'b1;
            r_validSync2 <= 1'b1;
            r_validPrev  <= 1'b1;
            r_codeSync1  <= 4'h0;
            r_codeSync2  <= 4'h0;
            r_strobe     <= 1'b0;
            r_last       <= 4'h0;
        end else begin
            r_validSync1 <= key_validn;
            r_validSync2 <= r_validSync1;
            r_validPrev  <= r_validSync2;
            r_codeSync1  <= key_code;
            r_codeSync2  <= r_codeSync1;
            r_strobe     <= w_fall;
            if (w_fall) begin
                r_last <= r_codeSync2;
            end
        end
    end

    assign key_strobe = r_strobe;
    assign key_last   = r_last;

endmodule

// File: rtl/combo_lock_rx.sv
// Combination lock fed by the keypad link. Define COMBO_LOCKOUT_EN to build
// the timed LOCKOUT state and alarm; otherwise fail_count simply saturates.
module combo_lock_rx
    import combo_pkg::*;
#(
    parameter int                     COMBO_LEN      = 4,
    parameter logic [4*COMBO_LEN-1:0] DEFAULT_COMBO  = 16'h1234,
    parameter int                     MAX_FAIL       = 3,
    parameter int                     LOCKOUT_CYCLES = 250_000_000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [3:0]                    key_code,
    input  logic                          key_validn,
    output logic                          key_strobe,
    output logic [3:0]                    key_last,
    output logic                          unlocked,
    output logic                          set_mode,
    output logic                          alarm,
    output logic [$clog2(MAX_FAIL+1)-1:0] fail_count,
    output logic [2:0]                    entry_count,
    output logic [4*COMBO_LEN-1:0]        entry
);

    localparam int         EW   = 4 * COMBO_LEN;
    localparam int         FW   = $clog2(MAX_FAIL + 1);
    localparam logic [2:0] FULL = 3'(COMBO_LEN);

    logic          w_keyStrobe;
    logic [3:0]    w_keyLast;

    lock_state_t   r_state,      w_stateNext;
    logic [EW-1:0] r_entry,      w_entryNext;
    logic [2:0]    r_entryCount, w_entryCountNext;
    logic [FW-1:0] r_failCount,  w_failCountNext;
    logic [EW-1:0] r_combo,      w_comboNext;

    logic [EW-1:0] w_entryShift;
    logic          w_collect;
    logic          w_match;
    logic [FW-1:0] w_failInc;

`ifdef COMBO_LOCKOUT_EN
    localparam int TW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
    logic [TW-1:0] r_timer, w_timerNext;
`endif

    key_rx_sync u_keyRx (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_code   (key_code),
        .key_validn (key_validn),
        .key_strobe (w_keyStrobe),
        .key_last   (w_keyLast)
    );

    assign w_entryShift = (r_entry << 4) | EW'(w_keyLast);
    assign w_collect    = w_keyStrobe && isDigit(w_keyLast) && (r_entryCount != FULL);
    assign w_match      = (r_entryCount == FULL) && (r_entry == r_combo);
    assign w_failInc    = r_failCount + FW'(1);

    always_comb begin
        w_stateNext      = r_state;
        w_entryNext      = r_entry;
        w_entryCountNext = r_entryCount;
        w_failCountNext  = r_failCount;
        w_comboNext      = r_combo;
`ifdef COMBO_LOCKOUT_EN
        w_timerNext      = r_timer;
`endif
        case (r_state)
            LOCKED: begin
                if (w_collect) begin
                    w_entryNext      = w_entryShift;
                    w_entryCountNext = r_entryCount + 3'd1;
                end else if (w_keyStrobe && w_keyLast == KEY_CLEAR) begin
                    w_entryNext      = '0;
                    w_entryCountNext = '0;
                end else if (w_keyStrobe && w_keyLast == KEY_ENTER) begin
                    w_stateNext = CHECK;
                end
            end
            CHECK: begin
                w_entryNext      = '0;
                w_entryCountNext = '0;
                if (w_match) begin
                    w_stateNext     = OPEN;
                    w_failCountNext = '0;
                end else begin
`ifdef COMBO_LOCKOUT_EN
                    w_failCountNext = w_failInc;
                    if (w_failInc == FW'(MAX_FAIL)) begin
                        w_stateNext = LOCKOUT;
                        w_timerNext = TW'(LOCKOUT_CYCLES - 1);
                    end else begin
                        w_stateNext = LOCKED;
                    end
`else
                    w_stateNext = LOCKED;
                    if (r_failCount != FW'(MAX_FAIL)) begin
                        w_failCountNext = w_failInc;
                    end
`endif
                end
            end
            OPEN: begin
                if (w_keyStrobe && w_keyLast == KEY_LOCK) begin
                    w_stateNext = LOCKED;
                end else if (w_keyStrobe && w_keyLast == KEY_SET) begin
                    w_stateNext      = SET;
                    w_entryNext      = '0;
                    w_entryCountNext = '0;
                end
            end
            SET: begin
                // A short entry on ENTER abandons the change, same as CLEAR.
                if (w_collect) begin
                    w_entryNext      = w_entryShift;
                    w_entryCountNext = r_entryCount + 3'd1;
                end else if (w_keyStrobe && (w_keyLast == KEY_ENTER || w_keyLast == KEY_CLEAR)) begin
                    if (w_keyLast == KEY_ENTER && r_entryCount == FULL) begin
                        w_comboNext = r_entry;
                    end
                    w_stateNext      = OPEN;
                    w_entryNext      = '0;
                    w_entryCountNext = '0;
                end
            end
`ifdef COMBO_LOCKOUT_EN
            LOCKOUT: begin
                if (r_timer == '0) begin
                    w_stateNext     = LOCKED;
                    w_failCountNext = '0;
                end else begin
                    w_timerNext = r_timer - TW'(1);
                end
            end
`endif
            default: begin
                w_stateNext = LOCKED;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= LOCKED;
            r_entry      <= '0;
            r_entryCount <= '0;
            r_failCount  <= '0;
            r_combo      <= DEFAULT_COMBO;
`ifdef COMBO_LOCKOUT_EN
            r_timer      <= '0;
`endif
        end else begin
            r_state      <= w_stateNext;
            r_entry      <= w_entryNext;
            r_entryCount <= w_entryCountNext;
            r_failCount  <= w_failCountNext;
            r_combo      <= w_comboNext;
`ifdef COMBO_LOCKOUT_EN
            r_timer      <= w_timerNext;
`endif
        end
    end

    assign key_strobe  = w_keyStrobe;
    assign key_last    = w_keyLast;
    assign unlocked    = (r_state == OPEN) || (r_state == SET);
    assign set_mode    = (r_state == SET);
`ifdef COMBO_LOCKOUT_EN
    assign alarm       = (r_state == LOCKOUT);
`else
    assign alarm       = 1'b0;
`endif
    assign fail_count  = r_failCount;
    assign entry_count = r_entryCount;
    assign entry       = r_entry;

endmodule
